// File: rtl/scan_word_fifo_if.sv
// Handshake and status bundle between a scan word FIFO and its producer/consumer.
// The master side drives requests and write data. The slave side (the FIFO) drives
// read data, level and the flags.
interface scan_word_fifo_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 4
);
    logic                  clear;
    logic                  wr_en;
    logic [DATA_WIDTH-1:0] data_in;
    logic                  rd_en;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  empty;
    logic                  full;
    logic                  almost_full;
    logic [ADDR_WIDTH:0]   level;
    logic                  overflow;
    logic                  underflow;

    modport master (
        output clear, wr_en, data_in, rd_en,
        input  data_out, empty, full, almost_full, level, overflow, underflow
    );

    modport slave (
        input  clear, wr_en, data_in, rd_en,
        output data_out, empty, full, almost_full, level, overflow, underflow
    );
endinterface

// File: rtl/scan_word_fifo.sv
// Single-clock word FIFO feeding the scan chain engine and collecting its results.
// Occupancy is tracked with a dedicated level counter, so the pointers can wrap freely.
// Read data is registered, with a latency of one cycle. Overflow and underflow are
// sticky debug flags.
module scan_word_fifo #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 4,
    parameter int AF_MARGIN  = 2
) (
    input  logic               aclk,
    input  logic               areset,
    scan_word_fifo_if.slave    fifo_if
);
    localparam int                  DEPTH    = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] LVL_FULL = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] LVL_AF   = (ADDR_WIDTH+1)'(DEPTH - AF_MARGIN);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [ADDR_WIDTH-1:0] wptr_q, wptr_d;
    logic [ADDR_WIDTH-1:0] rptr_q, rptr_d;
    logic [ADDR_WIDTH:0]   level_q, level_d;
    logic [DATA_WIDTH-1:0] dout_q, dout_d;
    logic                  ovf_q, ovf_d;
    logic                  unf_q, unf_d;

    logic empty_w, full_w, wr_acc, rd_acc;

    // The flags are decoded from the registered level. This way a same-cycle read
    // cannot make room for a write at full, and a same-cycle write cannot feed a
    // read at empty.
    assign empty_w = (level_q == '0);
    assign full_w  = (level_q == LVL_FULL);
    assign wr_acc  = fifo_if.wr_en && !full_w;
    assign rd_acc  = fifo_if.rd_en && !empty_w;

    // Next-state logic. A clear flushes the FIFO and swallows same-cycle requests
    // without flagging them.
    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        level_d = level_q;
        dout_d  = dout_q;
        ovf_d   = ovf_q;
        unf_d   = unf_q;
        if (fifo_if.clear) begin
            wptr_d  = '0;
            rptr_d  = '0;
            level_d = '0;
            ovf_d   = 1'b0;
            unf_d   = 1'b0;
        end else begin
            if (wr_acc) wptr_d = wptr_q + 1'b1;
            if (rd_acc) begin
                rptr_d = rptr_q + 1'b1;
                dout_d = mem[rptr_q];
            end
            case ({wr_acc, rd_acc})
                2'b10:   level_d = level_q + 1'b1;
                2'b01:   level_d = level_q - 1'b1;
                default: level_d = level_q;
            endcase
            if (fifo_if.wr_en && full_w)  ovf_d = 1'b1;
            if (fifo_if.rd_en && empty_w) unf_d = 1'b1;
        end
    end

    // Control and read-data registers. Reset also discards a read that is in flight.
    always_ff @(posedge aclk) begin
        if (areset) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
            dout_q  <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            level_q <= level_d;
            dout_q  <= dout_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    // Storage array. It has no reset, so its contents are undefined until written.
    always_ff @(posedge aclk) begin
        if (!areset && !fifo_if.clear && wr_acc)
            mem[wptr_q] <= fifo_if.data_in;
    end

    assign fifo_if.data_out    = dout_q;
    assign fifo_if.empty       = empty_w;
    assign fifo_if.full        = full_w;
    assign fifo_if.almost_full = (level_q >= LVL_AF);
    assign fifo_if.level       = level_q;
    assign fifo_if.overflow    = ovf_q;
    assign fifo_if.underflow   = unf_q;
endmodule
